hop_scheduler: RTL and testbench
================================

HOP_SCHEDULER -- requirements
Module: hop_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued hop commands (power of two, minimum 2).
REQ-002 SHALL have port frame_clk, input, 1 bit: the single clock, the frame-rate clock shared with the frog mover.
REQ-003 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port keycode, input, 8 bits: raw USB keycode, 0x00 when no key is pressed.
REQ-005 SHALL have port dead, input, 1 bit: frog killed this frame.
REQ-006 SHALL have port win, input, 1 bit: frog reached a home slot this frame.
REQ-007 SHALL have port cmd_ready, input, 1 bit: mover idle and able to accept a hop.
REQ-008 SHALL have port cmd_valid, output, 1 bit: a hop command is offered.
REQ-009 SHALL have port cmd_dir, output, 2 bits: hop direction of the offered command, type dir_t.
REQ-010 SHALL have port unpaused, output, 1 bit: game running.
REQ-011 SHALL have port manualreset, output, 1 bit: one-cycle restart pulse.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: queued entries.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, a hop was dropped.

Function
REQ-014 SHALL register keycode into lastkey every cycle; a key event is accepted only when lastkey==0x00 and keycode!=0x00.
REQ-015 SHALL decode the keycodes as follows: 0x1A UP, 0x07 RIGHT, 0x16 DOWN, 0x04 LEFT, 0x29 PAUSE, 0x15 RESTART; all other keycodes are ignored.
REQ-016 SHALL implement the states PAUSED, RUN and FLUSH.
REQ-017 SHALL apply these state transitions: PAUSE event toggles PAUSED<->RUN; dead, win or a RESTART event from any state moves to FLUSH; FLUSH lasts exactly one cycle and then returns to the mode held before entry.
REQ-018 SHALL resolve same-cycle events with priority dead/win > RESTART > PAUSE > arrow.
REQ-019 SHALL, in FLUSH, empty the FIFO, clear overflow, and force cmd_valid=0.
REQ-020 SHALL assert manualreset for exactly the FLUSH cycle entered via RESTART, and never for dead or win.
REQ-021 SHALL push an arrow event into the FIFO on the same edge it is accepted, only in state RUN; arrow events in PAUSED or FLUSH are discarded without setting overflow.
REQ-022 SHALL, on a push to a full FIFO, drop the command and set overflow.
REQ-023 SHALL complete a simultaneous push and pop when full, leaving fifo_count unchanged.
REQ-024 SHALL drive cmd_valid = (state==RUN) && (fifo_count!=0), with cmd_dir equal to the FIFO head, so the first command is visible the cycle after its push.
REQ-025 SHALL count a transfer on any edge where cmd_valid && cmd_ready is true, popping the head on that edge.
REQ-026 SHALL hold cmd_valid and cmd_dir stable until transfer, except that PAUSE or FLUSH may withdraw them.
REQ-027 SHALL retain queued entries across PAUSED, with dispatch resuming in FIFO order on return to RUN.
REQ-028 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and keep fifo_count saturated in the range 0..FIFO_DEPTH.

Reset
REQ-029 SHALL, while Reset_n=0, asynchronously force: state PAUSED, unpaused 0, FIFO empty, fifo_count 0, cmd_valid 0, cmd_dir UP, manualreset 0, overflow 0, lastkey 0x00.
REQ-030 SHALL discard any partial operation (pending push, offered command) on reset assertion; the first key event is honoured no earlier than the second edge after deassertion.

Structure
REQ-031 SHALL take from shared package frog_pkg: dir_t (UP=0, RIGHT=1, DOWN=2, LEFT=3), the keycode constants, and sched_state_t.
REQ-032 SHALL instantiate one sub-module, hop_fifo: a synchronous FIFO of dir_t with push, pop, flush and count.
REQ-033 SHALL fit in 120-400 lines of RTL in total.

Verification
REQ-034 SHALL cover: reset, then PAUSE (0x29, then 0x00), then RIGHT (0x07, then 0x00) with cmd_ready=1 -> unpaused=1, cmd_valid=1 with cmd_dir=1 one cycle after the push, transfer on the next edge, fifo_count returns to 0.
REQ-035 SHALL cover: cmd_ready=0, then five UP presses with FIFO_DEPTH=4 -> fifo_count=4, overflow=1, then with cmd_ready=1 exactly four UP transfers follow.
REQ-036 SHALL cover: keycode held at 0x1A for 10 cycles -> exactly one push.
REQ-037 SHALL cover: 3 entries queued, then dead=1 and RESTART in the same cycle -> one FLUSH cycle, FIFO empty, manualreset=0, unpaused unchanged.
REQ-038 SHALL cover: 2 entries queued, then PAUSE -> cmd_valid=0 and fifo_count=2 held; a LEFT press is ignored; PAUSE again -> both entries dispatched in order.
REQ-039 SHALL cover: Reset_n pulsed low mid-transfer with cmd_valid=1 -> all outputs take their reset values immediately, without waiting for frame_clk.

Source files
------------

// File: rtl/frog_pkg.sv
// Shared frog game types: hop directions, USB keycodes and scheduler states.
// Key decode helpers keep the scheduler's event logic free of keycode details.
package frog_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_FLUSH  = 2'd2
  } sched_state_t;

  localparam logic [7:0] KEY_NONE    = 8'h00;
  localparam logic [7:0] KEY_UP      = 8'h1A;
  localparam logic [7:0] KEY_RIGHT   = 8'h07;
  localparam logic [7:0] KEY_DOWN    = 8'h16;
  localparam logic [7:0] KEY_LEFT    = 8'h04;
  localparam logic [7:0] KEY_PAUSE   = 8'h29;
  localparam logic [7:0] KEY_RESTART = 8'h15;

  function automatic logic key_is_arrow(input logic [7:0] key);
    return (key == KEY_UP) || (key == KEY_RIGHT) ||
           (key == KEY_DOWN) || (key == KEY_LEFT);
  endfunction

  function automatic dir_t key_to_dir(input logic [7:0] key);
    dir_t dir;
    dir = DIR_UP;
    case (key)
      KEY_RIGHT: dir = DIR_RIGHT;
      KEY_DOWN:  dir = DIR_DOWN;
      KEY_LEFT:  dir = DIR_LEFT;
      default:   dir = DIR_UP;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/hop_scheduler_if.sv
// Hop command handshake between the scheduler (master) and the frog mover (slave).
interface hop_scheduler_if;
  import frog_pkg::*;

  logic cmd_valid;
  logic cmd_ready;
  dir_t cmd_dir;

  modport master (output cmd_valid, output cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/hop_fifo.sv
// Synchronous FIFO of hop directions; flush wins over push/pop, and a push
// into a full FIFO only lands when a pop frees a slot on the same edge.
module hop_fifo
  import frog_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     frame_clk,
  input  logic                     Reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  dir_t                     din,
  output dir_t                     dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);

  dir_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers are PW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= DIR_UP;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hop_scheduler.sv
// Turns keyboard edges into queued hop commands for the frog mover, with
// pause/run mode and a one-cycle FLUSH on death, win or restart.
module hop_scheduler
  import frog_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          frame_clk,
  input  logic                          Reset_n,
  input  logic [7:0]                    keycode,
  input  logic                          dead,
  input  logic                          win,
  hop_scheduler_if.master               cmd,
  output logic                          unpaused,
  output logic                          manualreset,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  sched_state_t state, state_next;
  logic [7:0]   lastkey;
  logic         armed;
  logic         resume_run, resume_run_next;
  logic         by_restart, by_restart_next;
  logic         key_event, ev_pause, ev_restart, ev_arrow;
  logic         push, pop, flush, fifo_full;

  // armed keeps a key held through reset from firing on the first edge after it.
  assign key_event  = armed && (lastkey == KEY_NONE) && (keycode != KEY_NONE);
  assign ev_pause   = key_event && (keycode == KEY_PAUSE);
  assign ev_restart = key_event && (keycode == KEY_RESTART);
  assign ev_arrow   = key_event && key_is_arrow(keycode);

  assign cmd.cmd_valid = (state == ST_RUN) && (fifo_count != '0);
  assign pop           = cmd.cmd_valid && cmd.cmd_ready;
  assign flush         = (state == ST_FLUSH) || (state_next == ST_FLUSH);
  assign manualreset   = (state == ST_FLUSH) && by_restart;
  assign unpaused      = (state == ST_RUN) || ((state == ST_FLUSH) && resume_run);

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_PAUSED;
      lastkey    <= KEY_NONE;
      armed      <= 1'b0;
      resume_run <= 1'b0;
      by_restart <= 1'b0;
    end else begin
      state      <= state_next;
      lastkey    <= keycode;
      armed      <= 1'b1;
      resume_run <= resume_run_next;
      by_restart <= by_restart_next;
    end
  end

  // A FLUSH re-entered from FLUSH keeps the mode remembered on first entry.
  always_comb begin
    state_next      = state;
    resume_run_next = resume_run;
    by_restart_next = by_restart;
    push            = 1'b0;
    if (dead || win || ev_restart) begin
      state_next      = ST_FLUSH;
      by_restart_next = !(dead || win);
      if (state != ST_FLUSH) resume_run_next = (state == ST_RUN);
    end else begin
      case (state)
        ST_PAUSED: if (ev_pause) state_next = ST_RUN;
        ST_RUN: begin
          if (ev_pause)      state_next = ST_PAUSED;
          else if (ev_arrow) push = 1'b1;
        end
        ST_FLUSH:  state_next = resume_run ? ST_RUN : ST_PAUSED;
        default:   state_next = ST_PAUSED;
      endcase
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n)                        overflow <= 1'b0;
    else if (flush)                      overflow <= 1'b0;
    else if (push && fifo_full && !pop)  overflow <= 1'b1;
  end

  hop_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .din       (key_to_dir(keycode)),
    .dout      (cmd.cmd_dir),
    .count     (fifo_count),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_hop_scheduler.sv
// Directed bench for hop_scheduler: expected hop directions are queued when a
// key is driven and popped by a monitor whenever a transfer is about to occur.
module tb_hop_scheduler;
  import frog_pkg::*;

  logic       frame_clk = 1'b0;
  logic       Reset_n   = 1'b0;
  logic [7:0] keycode   = 8'h00;
  logic       dead      = 1'b0;
  logic       win       = 1'b0;
  logic       unpaused, manualreset, overflow;
  logic [2:0] fifo_count;

  int   compared   = 0;
  int   mismatched = 0;
  int   xfer_count = 0;
  int   xfer_mark  = 0;
  dir_t sb [$];

  hop_scheduler_if cmd_if ();

  hop_scheduler #(
    .FIFO_DEPTH (4)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset_n     (Reset_n),
    .keycode     (keycode),
    .dead        (dead),
    .win         (win),
    .cmd         (cmd_if.master),
    .unpaused    (unpaused),
    .manualreset (manualreset),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One key press: keycode for one edge, then released for one edge.
  task automatic applyStimulus(input logic [7:0] key);
    keycode = key;
    tick();
    keycode = 8'h00;
    tick();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"},    32'(cmd_if.cmd_valid), 32'd0);
    checkOutput({tag, "_dir"},      32'(cmd_if.cmd_dir),   32'd0);
    checkOutput({tag, "_unpaused"}, 32'(unpaused),         32'd0);
    checkOutput({tag, "_mreset"},   32'(manualreset),      32'd0);
    checkOutput({tag, "_count"},    32'(fifo_count),       32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow),         32'd0);
  endtask

  // Inputs settle 1 time unit after each rising edge, so the falling edge sees
  // exactly what the next rising edge will act on.
  always @(negedge frame_clk) begin
    if (Reset_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $error("[TB] FAIL xfer_unexpected: observed dir %0d expected no transfer",
               cmd_if.cmd_dir);
      end else begin
        dir_t exp_dir;
        exp_dir = sb.pop_front();
        assert (cmd_if.cmd_dir === exp_dir) else begin
          mismatched++;
          $error("[TB] FAIL xfer_dir: observed %0d expected %0d", cmd_if.cmd_dir, exp_dir);
        end
      end
      xfer_count++;
    end
  end

  initial begin
    cmd_if.cmd_ready = 1'b1;
    tick();
    tick();
    checkReset("reset");
    Reset_n = 1'b1;
    tick();

    // Unpause, then a single RIGHT hop dispatched straight away.
    applyStimulus(KEY_PAUSE);
    checkOutput("pause_unpaused", 32'(unpaused), 32'd1);
    keycode = KEY_RIGHT;
    sb.push_back(DIR_RIGHT);
    tick();
    checkOutput("right_valid", 32'(cmd_if.cmd_valid), 32'd1);
    checkOutput("right_dir",   32'(cmd_if.cmd_dir),   32'(DIR_RIGHT));
    checkOutput("right_count", 32'(fifo_count),       32'd1);
    keycode = 8'h00;
    tick();
    checkOutput("right_drained", 32'(fifo_count),       32'd0);
    checkOutput("right_idle",    32'(cmd_if.cmd_valid), 32'd0);

    // Five UP presses into a 4-deep FIFO with the mover stalled.
    cmd_if.cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back(DIR_UP);
      applyStimulus(KEY_UP);
    end
    checkOutput("ovf_count", 32'(fifo_count), 32'd4);
    checkOutput("ovf_flag",  32'(overflow),   32'd1);
    xfer_mark = xfer_count;
    cmd_if.cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("ovf_xfers",  32'(xfer_count - xfer_mark), 32'd4);
    checkOutput("ovf_empty",  32'(fifo_count),             32'd0);
    checkOutput("ovf_sticky", 32'(overflow),               32'd1);

    // A held key produces one push only.
    cmd_if.cmd_ready = 1'b0;
    keycode = KEY_UP;
    sb.push_back(DIR_UP);
    for (int i = 0; i < 10; i++) tick();
    keycode = 8'h00;
    tick();
    checkOutput("hold_count", 32'(fifo_count), 32'd1);
    cmd_if.cmd_ready = 1'b1;
    tick();
    checkOutput("hold_drained", 32'(fifo_count), 32'd0);

    // dead together with RESTART: silent flush that keeps RUN mode.
    cmd_if.cmd_ready = 1'b0;
    applyStimulus(KEY_UP);
    applyStimulus(KEY_DOWN);
    applyStimulus(KEY_LEFT);
    checkOutput("flush_pre_count", 32'(fifo_count), 32'd3);
    dead    = 1'b1;
    keycode = KEY_RESTART;
    tick();
    dead    = 1'b0;
    keycode = 8'h00;
    checkOutput("flush_mreset",   32'(manualreset),      32'd0);
    checkOutput("flush_count",    32'(fifo_count),       32'd0);
    checkOutput("flush_valid",    32'(cmd_if.cmd_valid), 32'd0);
    checkOutput("flush_overflow", 32'(overflow),         32'd0);
    checkOutput("flush_unpaused", 32'(unpaused),         32'd1);
    tick();
    checkOutput("flush_done_mreset",   32'(manualreset), 32'd0);
    checkOutput("flush_done_unpaused", 32'(unpaused),    32'd1);

    // RESTART alone pulses manualreset for the single FLUSH cycle.
    keycode = KEY_RESTART;
    tick();
    keycode = 8'h00;
    checkOutput("restart_mreset", 32'(manualreset), 32'd1);
    tick();
    checkOutput("restart_mreset_off", 32'(manualreset), 32'd0);
    checkOutput("restart_unpaused",   32'(unpaused),    32'd1);

    // Entries survive a pause; a LEFT while paused is ignored.
    sb.push_back(DIR_DOWN);
    applyStimulus(KEY_DOWN);
    sb.push_back(DIR_LEFT);
    applyStimulus(KEY_LEFT);
    applyStimulus(KEY_PAUSE);
    checkOutput("pause_valid",    32'(cmd_if.cmd_valid), 32'd0);
    checkOutput("pause_unpaused", 32'(unpaused),         32'd0);
    cmd_if.cmd_ready = 1'b1;
    applyStimulus(KEY_LEFT);
    checkOutput("pause_count",    32'(fifo_count), 32'd2);
    checkOutput("pause_overflow", 32'(overflow),   32'd0);
    applyStimulus(KEY_PAUSE);
    tick();
    checkOutput("resume_count", 32'(fifo_count), 32'd0);

    // Asynchronous reset while a command is on offer.
    cmd_if.cmd_ready = 1'b0;
    keycode = KEY_UP;
    tick();
    keycode = 8'h00;
    checkOutput("async_pre_valid", 32'(cmd_if.cmd_valid), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    checkReset("async");
    tick();
    Reset_n = 1'b1;
    tick();
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
